maxpool2x2_stream: RTL and testbench

Streaming 2x2 max-pooling stage placed directly downstream of the convolution MAC/saturation stage. It consumes the saturated signed 8-bit convolution outputs in raster order and emits one pooled signed 8-bit value per 2x2 window. A half-width line buffer holds the horizontal pair maxima of each even row, so the stage needs no frame storage. Pooled results are passed to the next layer with a valid strobe and a last-of-frame flag.

---
 rtl/maxpool2x2_stream.sv | 99 +++++++++
 tb/tb_maxpool2x2_stream.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 signed max-pool over raster-order conv outputs; optional ReLU fused in via RELU_EN.
// Latency: out_valid one cycle after the odd-row/odd-col input pixel.
// Backpressure: none; downstream must take every out_valid strobe, bubbles on in_valid are absorbed.
module maxpool2x2_stream #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              in_valid,
    input  logic signed [7:0] in_data,
    output logic              out_valid,
    output logic signed [7:0] out_data,
    output logic              out_last
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int LW = (IMG_W > 2) ? $clog2(IMG_W / 2) : 1;

    function automatic logic signed [7:0] smax(input logic signed [7:0] a,
                                               input logic signed [7:0] b);
        return (a > b) ? a : b;
    endfunction

    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic signed [7:0] h_reg;
    logic signed [7:0] linebuf [IMG_W/2];

    logic [CW-1:0]     cur_col;
    logic [RW-1:0]     cur_row;
    logic [LW-1:0]     lb_idx;
    logic signed [7:0] pix;
    logic signed [7:0] hmax;
    logic              col_odd;
    logic              row_odd;
    logic              col_end;
    logic              row_end;

    // frame_start retargets the current pixel to (0,0) before anything is decided from position.
    always_comb begin
        cur_col = frame_start ? '0 : col;
        cur_row = frame_start ? '0 : row;
        lb_idx  = LW'(cur_col >> 1);
        col_odd = cur_col[0];
        row_odd = cur_row[0];
        col_end = (cur_col == CW'(IMG_W - 1));
        row_end = (cur_row == RW'(IMG_H - 1));
`ifdef RELU_EN
        pix = (in_data < 0) ? 8'sd0 : in_data;
`else
        pix = in_data;
`endif
        hmax = smax(h_reg, pix);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            col       <= '0;
            row       <= '0;
            h_reg     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (in_valid) begin
                if (!col_odd) begin
                    h_reg <= pix;
                end else if (row_odd) begin
                    out_valid <= 1'b1;
                    out_data  <= smax(linebuf[lb_idx], hmax);
                    out_last  <= row_end && col_end;
                end
                if (col_end) begin
                    col <= '0;
                    row <= row_end ? '0 : cur_row + RW'(1);
                end else begin
                    col <= cur_col + CW'(1);
                    row <= cur_row;
                end
            end else if (frame_start) begin
                col <= '0;
                row <= '0;
            end
        end
    end

    // Line buffer is deliberately left unreset; every odd row reads only entries its even row just wrote.
    always_ff @(posedge clk) begin
        if (reset && in_valid && col_odd && !row_odd) begin
            linebuf[lb_idx] <= hmax;
        end
    end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Directed bench for maxpool2x2_stream at 4x4: tables of pixels with expected pooled outputs.
module tb_maxpool2x2_stream;

    logic              clk = 1'b0;
    logic              reset;
    logic              frame_start;
    logic              in_valid;
    logic signed [7:0] in_data;
    logic              out_valid;
    logic signed [7:0] out_data;
    logic              out_last;

    int errors = 0;
    int checks = 0;
    logic signed [7:0] exp_hold;

    typedef struct {
        logic signed [7:0] d;
        logic              ev;
        logic signed [7:0] ed;
        logic              el;
    } vec_t;

    vec_t f1 [16];
    vec_t f2 [16];

    maxpool2x2_stream #(.IMG_W(4), .IMG_H(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_last    (out_last)
    );

    always #5 clk = ~clk;

    function automatic logic signed [7:0] ex(input logic signed [7:0] v);
`ifdef RELU_EN
        return (v < 0) ? 8'sd0 : v;
`else
        return v;
`endif
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    // One clock: drive on the falling edge, sample 1 ns after the rising edge.
    task automatic step(input logic fs, input logic iv, input logic signed [7:0] d,
                        input logic ev, input logic signed [7:0] ed, input logic el,
                        input string nm);
        @(negedge clk);
        frame_start = fs;
        in_valid    = iv;
        in_data     = d;
        @(posedge clk);
        #1;
        if (ev) exp_hold = ex(ed);
        chk({nm, " out_valid"}, int'(out_valid), int'(ev));
        chk({nm, " out_last"},  int'(out_last),  int'(el));
        chk({nm, " out_data"},  int'(out_data),  int'(exp_hold));
    endtask

    task automatic run_frame(input int which, input int first, input int last,
                             input logic fs_first, input int max_bubbles, input string nm);
        vec_t v;
        for (int i = first; i <= last; i++) begin
            v = (which == 1) ? f1[i] : f2[i];
            for (int b = 0; b < $urandom_range(max_bubbles, 0); b++)
                step(1'b0, 1'b0, 8'sh55, 1'b0, 8'sd0, 1'b0, {nm, " bubble"});
            step(fs_first && (i == first), 1'b1, v.d, v.ev, v.ed, v.el,
                 $sformatf("%s px%0d", nm, i));
        end
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        reset       = 1'b0;
        frame_start = 1'b1;
        in_valid    = 1'b1;
        in_data     = 8'sd100;
        @(posedge clk);
        #1;
        exp_hold = 8'sd0;
        chk({nm, " out_valid"}, int'(out_valid), 0);
        chk({nm, " out_data"},  int'(out_data),  0);
        chk({nm, " out_last"},  int'(out_last),  0);
        @(negedge clk);
        reset       = 1'b1;
        frame_start = 1'b0;
        in_valid    = 1'b0;
    endtask

    initial begin
        int d1 [16] = '{1, 5, -3, 2, 4, -7, 9, 0, -20, -20, -20, -20, -20, -20, -20, -1};
        int d2 [16] = '{-128, -5, 3, -4, -9, -128, -4, -2, 0, 0, 0, 0, 7, -8, 127, -128};
        int e1 [16] = '{0, 0, 0, 0, 0, 5, 0, 9, 0, 0, 0, 0, 0, -20, 0, -1};
        int e2 [16] = '{0, 0, 0, 0, 0, -5, 0, 3, 0, 0, 0, 0, 0, 7, 0, 127};
        for (int i = 0; i < 16; i++) begin
            f1[i].d  = 8'(d1[i]);
            f1[i].ev = (i % 4 == 1 || i % 4 == 3) && ((i / 4) % 2 == 1);
            f1[i].ed = 8'(e1[i]);
            f1[i].el = (i == 15);
            f2[i].d  = 8'(d2[i]);
            f2[i].ev = f1[i].ev;
            f2[i].ed = 8'(e2[i]);
            f2[i].el = (i == 15);
        end

        reset       = 1'b0;
        frame_start = 1'b0;
        in_valid    = 1'b0;
        in_data     = 8'sd0;
        exp_hold    = 8'sd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset out_data",  int'(out_data),  0);
        chk("reset out_last",  int'(out_last),  0);
        @(negedge clk);
        reset = 1'b1;

        // Back-to-back frames without gaps, then the same first frame with bubbles.
        run_frame(1, 0, 15, 1'b0, 0, "f1");
        run_frame(2, 0, 15, 1'b0, 0, "f2neg");
        run_frame(1, 0, 15, 1'b0, 2, "f1bub");

        // Abort mid-frame after row1 col0, then a fresh frame from (0,0).
        run_frame(2, 0, 4, 1'b0, 0, "abort");
        do_reset("midreset");
        step(1'b0, 1'b0, 8'sd0, 1'b0, 8'sd0, 1'b0, "post-reset idle");
        run_frame(1, 0, 15, 1'b0, 0, "fresh");

        // Restart at row2 col1: that pixel becomes (0,0) of a full new frame.
        run_frame(1, 0, 8, 1'b0, 0, "partial");
        run_frame(2, 0, 15, 1'b1, 0, "fsrestart");

        // frame_start with bubble only: counters restart, next frame pools from (0,0).
        run_frame(1, 0, 2, 1'b0, 0, "fsidle-pre");
        step(1'b1, 1'b0, 8'sd0, 1'b0, 8'sd0, 1'b0, "fsidle");
        run_frame(1, 0, 15, 1'b0, 1, "fsidle-post");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit, expected completion");
        $fatal(1);
    end

endmodule
